// File: rtl/chatgpt_snn_mtomlin5.sv
// ---------------------------------------------------------------------------
// chatgpt_snn_mtomlin5
// Small spiking neural network tile: 3 input spike lines fully connected to
// 8 leaky integrate-and-fire neurons. Weights, threshold and leak are loaded
// through a write-only SPI slave (mode 0, MSB first, 16-bit frame addr/data).
//
// Ports:
//   clk      system clock, all state updates on the rising edge
//   rst      asynchronous active-high reset
//   ena      design enable; low holds membrane potentials, forces uo_out to 0
//   ui_in    [0]=spi_sck [1]=spi_cs_n [2]=spi_copi [5:3]=spikes_in [7:6]=unused
//   uo_out   registered spike of neuron j on bit j (1-cycle pulse per firing)
//   uio_in   unused
//   uio_out  constant 0
//   uio_oe   constant 0 (bidirectional pins all inputs)
// ---------------------------------------------------------------------------
module chatgpt_snn_mtomlin5 #(
    parameter int NUM_IN  = 3,
    parameter int NUM_OUT = 8,
    parameter int W_WIDTH = 8,
    parameter int V_WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int NUM_W = NUM_IN * NUM_OUT;
    // Wide enough for V(255) + 3*127 and for 0 - 3*128 - 255.
    localparam int S_W   = 11;

    // Pins with no function; the name keeps lint from reporting them.
    logic unused_ok;
    assign unused_ok = &{1'b0, ui_in[7:6], uio_in};

    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

    // ------------------------------------------------------------------
    // Input synchronizers and registered spikes
    // ------------------------------------------------------------------
    logic              sck_meta_q, sck_sync_q, sck_prev_q;
    logic              cs_meta_q, cs_sync_q;
    logic              copi_meta_q, copi_sync_q;
    logic [NUM_IN-1:0] spk_q;

    // Two-flop synchronizers for the SPI pins, sck history for edge detect,
    // and a single register stage for the spike inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_meta_q  <= 1'b0;
            sck_sync_q  <= 1'b0;
            sck_prev_q  <= 1'b0;
            cs_meta_q   <= 1'b1;
            cs_sync_q   <= 1'b1;
            copi_meta_q <= 1'b0;
            copi_sync_q <= 1'b0;
            spk_q       <= {NUM_IN{1'b0}};
        end else begin
            sck_meta_q  <= ui_in[0];
            sck_sync_q  <= sck_meta_q;
            sck_prev_q  <= sck_sync_q;
            cs_meta_q   <= ui_in[1];
            cs_sync_q   <= cs_meta_q;
            copi_meta_q <= ui_in[2];
            copi_sync_q <= copi_meta_q;
            spk_q       <= ui_in[5:3];
        end
    end

    logic sck_rise_s;
    assign sck_rise_s = sck_sync_q & ~sck_prev_q;

    // ------------------------------------------------------------------
    // SPI frame receiver
    // ------------------------------------------------------------------
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [15:0] shift_q, shift_d;
    logic        wr_pend_q, wr_pend_d;
    logic [15:0] wr_frame_q, wr_frame_d;

    // Shift in bits while selected; the 16th bit captures a complete frame
    // and raises a one-cycle write strobe. The counter saturates at 16 so
    // trailing bits in the same selection are dropped.
    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        wr_pend_d  = 1'b0;
        wr_frame_d = wr_frame_q;
        if (cs_sync_q) begin
            bit_cnt_d = 5'd0;
            shift_d   = 16'h0000;
        end else if (sck_rise_s && (bit_cnt_q < 5'd16)) begin
            shift_d   = {shift_q[14:0], copi_sync_q};
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd15) begin
                wr_pend_d  = 1'b1;
                wr_frame_d = {shift_q[14:0], copi_sync_q};
            end else begin
                wr_pend_d  = 1'b0;
            end
        end else begin
            bit_cnt_d = bit_cnt_q;
        end
    end

    // SPI receiver state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt_q  <= 5'd0;
            shift_q    <= 16'h0000;
            wr_pend_q  <= 1'b0;
            wr_frame_q <= 16'h0000;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            wr_pend_q  <= wr_pend_d;
            wr_frame_q <= wr_frame_d;
        end
    end

    // ------------------------------------------------------------------
    // Configuration registers
    // ------------------------------------------------------------------
    logic [W_WIDTH-1:0] w_q [NUM_W];
    logic [W_WIDTH-1:0] w_d [NUM_W];
    logic [7:0]         thr_q, thr_d;
    logic [7:0]         leak_q, leak_d;
    logic [7:0]         wr_addr_s, wr_data_s;

    assign wr_addr_s = wr_frame_q[15:8];
    assign wr_data_s = wr_frame_q[7:0];

    // Register-map decode; the full 8-bit address is compared so that
    // unmapped addresses never alias onto a real register.
    always_comb begin
        w_d    = w_q;
        thr_d  = thr_q;
        leak_d = leak_q;
        if (wr_pend_q) begin
            if (wr_addr_s < 8'(NUM_W)) begin
                w_d[wr_addr_s[4:0]] = wr_data_s;
            end else if (wr_addr_s == 8'h18) begin
                thr_d = wr_data_s;
            end else if (wr_addr_s == 8'h19) begin
                leak_d = wr_data_s;
            end else begin
                thr_d = thr_q;
            end
        end else begin
            thr_d = thr_q;
        end
    end

    // Configuration register file.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_W; k++) begin
                w_q[k] <= {W_WIDTH{1'b0}};
            end
            thr_q  <= 8'h10;
            leak_q <= 8'h00;
        end else begin
            w_q    <= w_d;
            thr_q  <= thr_d;
            leak_q <= leak_d;
        end
    end

    // ------------------------------------------------------------------
    // LIF neurons
    // ------------------------------------------------------------------
    logic [V_WIDTH-1:0] v_q [NUM_OUT];
    logic [V_WIDTH-1:0] v_d [NUM_OUT];
    logic [NUM_OUT-1:0] fire_s;
    logic [NUM_OUT-1:0] spike_q, spike_d;

    // Integrate, leak and fire. The compare uses the raw signed sum, so a
    // negative sum never fires even with a zero threshold; only the stored
    // potential is clamped to 0..255.
    always_comb begin
        logic signed [S_W-1:0] acc;
        fire_s  = {NUM_OUT{1'b0}};
        spike_d = {NUM_OUT{1'b0}};
        for (int j = 0; j < NUM_OUT; j++) begin
            acc = $signed({3'b000, v_q[j]});
            for (int i = 0; i < NUM_IN; i++) begin
                if (spk_q[i]) begin
                    acc = acc + $signed({{3{w_q[j*NUM_IN+i][W_WIDTH-1]}}, w_q[j*NUM_IN+i]});
                end else begin
                    acc = acc;
                end
            end
            acc = acc - $signed({3'b000, leak_q});
            fire_s[j] = (acc >= $signed({3'b000, thr_q}));
            if (!ena) begin
                v_d[j] = v_q[j];
            end else if (fire_s[j]) begin
                v_d[j] = 8'd0;
            end else if (acc < $signed(11'sd0)) begin
                v_d[j] = 8'd0;
            end else if (acc > $signed(11'sd255)) begin
                v_d[j] = 8'd255;
            end else begin
                v_d[j] = acc[7:0];
            end
        end
        if (ena) begin
            spike_d = fire_s;
        end else begin
            spike_d = {NUM_OUT{1'b0}};
        end
    end

    // Membrane potentials and registered output spikes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_OUT; k++) begin
                v_q[k] <= {V_WIDTH{1'b0}};
            end
            spike_q <= {NUM_OUT{1'b0}};
        end else begin
            v_q     <= v_d;
            spike_q <= spike_d;
        end
    end

    assign uo_out = spike_q;

endmodule

// File: tb/tb_chatgpt_snn_mtomlin5.sv
// Directed bench for the SNN tile: SPI configuration frames, hand-computed
// spike patterns, enable, abort and asynchronous reset behaviour.
module tb_chatgpt_snn_mtomlin5;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ena = 1'b1;
    logic       sck = 1'b0;
    logic       cs_n = 1'b1;
    logic       copi = 1'b0;
    logic [2:0] spikes = 3'b000;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int err_cnt = 0;
    int chk_cnt = 0;

    assign ui_in = {2'b00, spikes, copi, cs_n, sck};

    always #5 clk = ~clk;

    chatgpt_snn_mtomlin5 dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        spikes = 3'b000;
        sck    = 1'b0;
        cs_n   = 1'b1;
        copi   = 1'b0;
        ena    = 1'b1;
        #2 rst = 1'b1;
        wait_clk(3);
        rst = 1'b0;
        wait_clk(2);
    endtask

    // Send the first nbits of a 16-bit frame, MSB first, sck 3 clk high/low.
    task automatic spi_frame(input logic [7:0] addr, input logic [7:0] data, input int nbits);
        logic [15:0] frame;
        frame = {addr, data};
        cs_n = 1'b0;
        wait_clk(4);
        for (int b = 0; b < nbits; b++) begin
            copi = frame[15-b];
            wait_clk(3);
            sck = 1'b1;
            wait_clk(3);
            sck = 1'b0;
        end
        wait_clk(4);
        cs_n = 1'b1;
        wait_clk(5);
    endtask

    // Sample uo_out on the falling edge after each of the next n rising edges.
    // bits[k] = uo_out[sel] after edge k+1; others = OR of all other outputs.
    task automatic capture(input int sel, input int n, output logic [31:0] bits, output logic [7:0] others);
        logic [7:0] mask;
        mask   = 8'h01 << sel;
        bits   = 32'h0;
        others = 8'h00;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            @(negedge clk);
            bits[k] = uo_out[sel];
            others  = others | (uo_out & ~mask);
        end
    endtask

    logic [31:0] bits;
    logic [7:0]  others;
    int          pos[4];
    int          npos;

    initial begin
        // ---------------- reset state ----------------
        #2 rst = 1'b1;
        #1;
        check_eq("rst_uo_out", {24'h0, uo_out}, 32'h00);
        check_eq("rst_uio_out", {24'h0, uio_out}, 32'h00);
        check_eq("rst_uio_oe", {24'h0, uio_oe}, 32'h00);
        wait_clk(3);
        rst = 1'b0;
        wait_clk(2);

        // ------ zero weights, unmapped writes must not alias ------
        spi_frame(8'h38, 8'h00, 16);  // would set threshold 0 if aliased
        spi_frame(8'h20, 8'h7F, 16);  // would set w[0][0] if aliased
        spikes = 3'b111;
        capture(0, 25, bits, others);
        check_eq("zero_w_n0", bits, 32'h0);
        capture(0, 25, bits, others);
        check_eq("zero_w_all", {24'h0, others}, 32'h00);

        // ---------------- basic integrate/fire + enable ----------------
        do_reset();
        spi_frame(8'h00, 8'h08, 16);
        spi_frame(8'h18, 8'h10, 16);
        spikes = 3'b001;
        capture(0, 8, bits, others);
        check_eq("alt_pattern", bits, 32'h54);
        check_eq("alt_others", {24'h0, others}, 32'h00);
        // V is 8 here; hold it with ena low, then it must fire on the first enabled edge
        ena = 1'b0;
        capture(0, 5, bits, others);
        check_eq("ena_low_out", bits | {24'h0, others}, 32'h0);
        ena = 1'b1;
        capture(0, 1, bits, others);
        check_eq("ena_resume", bits, 32'h1);

        // ---------------- fire every cycle, then async reset ----------------
        do_reset();
        spi_frame(8'h03, 8'h05, 16);
        spi_frame(8'h04, 8'h05, 16);
        spi_frame(8'h05, 8'h05, 16);
        spi_frame(8'h18, 8'h0F, 16);
        spikes = 3'b111;
        capture(1, 8, bits, others);
        check_eq("every_cycle_n1", bits, 32'hFE);
        check_eq("every_cycle_others", {24'h0, others}, 32'h00);
        #2 rst = 1'b1;
        #1;
        check_eq("async_rst_uo", {24'h0, uo_out}, 32'h00);
        wait_clk(2);
        rst = 1'b0;
        capture(1, 10, bits, others);
        check_eq("post_rst_weights", bits | {24'h0, others}, 32'h0);

        // ---------------- inhibition and clamp ----------------
        do_reset();
        spi_frame(8'h00, 8'h08, 16);
        spi_frame(8'h01, 8'hF8, 16);
        spikes = 3'b011;
        capture(0, 20, bits, others);
        check_eq("inhibit_n0", bits, 32'h0);
        spikes = 3'b010;
        wait_clk(5);
        // a wrapped potential (0xF8) would fire on the first edge below
        spikes = 3'b001;
        capture(0, 8, bits, others);
        check_eq("clamp_zero", bits, 32'h54);

        // ---------------- leak ----------------
        do_reset();
        spi_frame(8'h06, 8'h04, 16);
        spi_frame(8'h19, 8'h04, 16);
        spikes = 3'b001;
        capture(2, 30, bits, others);
        check_eq("leak_cancel", bits | {24'h0, others}, 32'h0);
        spi_frame(8'h19, 8'h02, 16);
        wait_clk(10);
        capture(2, 32, bits, others);
        npos = 0;
        for (int k = 0; k < 32; k++) begin
            if (bits[k]) begin
                if (npos < 4) pos[npos] = k;
                npos++;
            end
        end
        check_eq("leak_fire_count", npos, 4);
        if (npos >= 4) begin
            check_eq("leak_period", pos[1] - pos[0], 8);
            check_eq("leak_period_3", pos[3] - pos[0], 24);
        end
        check_eq("leak_others", {24'h0, others}, 32'h00);

        // ---------------- SPI abort ----------------
        do_reset();
        spi_frame(8'h18, 8'h05, 10);
        spi_frame(8'h00, 8'h08, 16);
        spikes = 3'b001;
        capture(0, 8, bits, others);
        check_eq("abort_thr_kept", bits, 32'h54);
        spikes = 3'b000;
        spi_frame(8'h18, 8'h08, 16);
        spikes = 3'b001;
        capture(0, 8, bits, others);
        check_eq("after_abort_write", bits & 32'hFE, 32'hFE);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout: got no completion expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/chatgpt_snn_mtomlin5.md
Name: chatgpt_snn_mtomlin5

Overview:
- Small spiking neural network tile: 3 input spike lines fully connected to 8 leaky integrate-and-fire (LIF) output neurons.
- Synaptic weights, firing threshold and leak are written over a write-only SPI slave (mode 0).
- Sits directly behind the Tiny Tapeout pin wrapper; output spikes drive the 8 dedicated outputs.

Parameters:
- NUM_IN, 3, number of input spike lines.
- NUM_OUT, 8, number of LIF output neurons.
- W_WIDTH, 8, signed synaptic weight width.
- V_WIDTH, 8, unsigned membrane potential width.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- ena  in  1  design enable; low freezes neuron state.
- ui_in  in  8  [0]=spi_sck, [1]=spi_cs_n, [2]=spi_copi, [5:3]=spikes_in[2:0], [7:6] unused.
- uo_out  out  8  output spike of neuron j on bit j.
- uio_in  in  8  unused.
- uio_out  out  8  constant 0.
- uio_oe  out  8  constant 0 (all inputs).

Behaviour:
- Reset (async, rst=1):
  - all weights 0x00; threshold 0x10; leak 0x00.
  - all membrane potentials 0; uo_out 0.
  - SPI shift register and bit counter cleared.
- Input sync:
  - spi_sck, spi_cs_n, spi_copi each pass through 2-FF synchronizers.
  - spikes_in[2:0] is registered once.
- SPI (mode 0, MSB first):
  - sck rising edge is detected on the synchronized signal; it must be high and low for at least 2 clk each.
  - While cs_n is high: bit counter held at 0.
  - While cs_n is low: each sck rise shifts copi into a 16-bit shift register; frame = addr[7:0] then data[7:0].
  - On the 16th bit, write data to addr. Later bits in the same frame are ignored until cs_n goes high.
  - Register map:
    - 0x00–0x17: weight w[j][i], addr = j*3+i, signed 8-bit.
    - 0x18: threshold, unsigned 8-bit.
    - 0x19: leak, unsigned 8-bit.
    - Other addresses: write ignored.
  - A write takes effect in the clk cycle after the 16th-bit sample.
  - cs_n deasserted mid-frame aborts the frame; no write occurs.
- Neuron update (each clk with ena=1, per neuron j):
  - s = V + sum over i of (spk_r[i] ? w[j][i] : 0) − leak, computed signed 11-bit.
  - If s >= threshold (signed compare, threshold zero-extended): spike_j=1 and V=0.
  - Else: spike_j=0 and V = clamp(s, 0, 255).
  - uo_out[j] is registered spike_j: a 1-cycle pulse per firing.
  - Threshold 0 makes neurons fire every enabled cycle (s>=0 after clamp semantics apply to compare on raw s; s<0 never fires).
- Latency: spikes_in sampled at edge k → spk_r valid after k → integrate/fire at edge k+1 → uo_out visible after edge k+1.
- ena=0: V held, uo_out forced to 0. The SPI slave keeps operating.
- Reset mid-operation: everything returns to reset values immediately; any SPI frame in progress is lost.

Test Plan:
- Reset, no SPI writes, spikes_in=3'b111 for 50 cycles → uo_out stays 0x00 (weights 0).
- Write 0x00←0x08, 0x18←0x10, spikes_in=3'b001 held → uo_out[0] pattern 0,1,0,1… (V 8→16 fires, reset); other bits 0.
- Write w[1][*]=0x05 (addrs 0x03–0x05), threshold 0x0F, spikes_in=3'b111 → uo_out[1] fires every cycle (s=15).
- Inhibition: w[0][0]=0x08, w[0][1]=0xF8 (−8), spikes_in=3'b011 → uo_out[0] never fires, V stays 0 (clamp).
- Leak: w[2][0]=0x04, leak 0x04, threshold 0x10, spikes_in=3'b001 → no spikes; then leak 0x02 → neuron 2 fires every 8th cycle.
- SPI abort: raise cs_n after 10 bits of a frame to 0x18 → threshold unchanged (0x10); next full frame writes correctly. Async rst mid-run → uo_out 0x00 immediately, weights cleared.
